// File: rtl/systolic_skew_feeder.sv
// Skew feeder for an S x S systolic array: holds one A tile and one B tile and
// streams them diagonally so that operand pairs meet at the correct processing element (PE).
module systolic_skew_feeder #(
    parameter int N  = 8,
    parameter int S  = 8,
    parameter int AW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic           wr_sel,
    input  logic [AW-1:0]  wr_addr,
    input  logic [S*N-1:0] wr_data,
    input  logic           start,
    output logic [S*N-1:0] a_out,
    output logic [S*N-1:0] b_out,
    output logic           sn,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    localparam int            TW     = $clog2(3 * S);
    localparam logic [TW-1:0] T_LAST = TW'(3 * S - 3);

    state_t         state;
    logic [TW-1:0]  t;
    logic [TW-1:0]  tn;
    logic           wr_ok;
    logic [N-1:0]   a_mem [S][S];
    logic [N-1:0]   b_mem [S][S];
    logic [N-1:0]   a_nx  [S][S];
    logic [N-1:0]   b_nx  [S][S];
    logic [S*N-1:0] a_lanes;
    logic [S*N-1:0] b_lanes;

    assign wr_ok = wr_en && (state == IDLE) && ({1'b0, wr_addr} < (AW + 1)'(S));

    // Tile contents as they will be after this edge; a write in the start cycle is visible to step 0.
    always_comb begin
        a_nx = a_mem;
        b_nx = b_mem;
        if (wr_ok) begin
            for (int j = 0; j < S; j++) begin
                if (!wr_sel) a_nx[wr_addr][j] = wr_data[S*N-1-j*N -: N];
                else         b_nx[wr_addr][j] = wr_data[S*N-1-j*N -: N];
            end
        end
    end

    assign tn = (state == IDLE) ? '0 : t + 1'b1;

    always_comb begin
        a_lanes = '0;
        b_lanes = '0;
        for (int r = 0; r < S; r++) begin
            for (int k = 0; k < S; k++) begin
                if (int'(tn) == r + k) begin
                    a_lanes[S*N-1-r*N -: N] = a_nx[r][k];
                    b_lanes[S*N-1-r*N -: N] = b_nx[k][r];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < S; r++) begin
                for (int c = 0; c < S; c++) begin
                    a_mem[r][c] <= '0;
                    b_mem[r][c] <= '0;
                end
            end
        end else begin
            a_mem <= a_nx;
            b_mem <= b_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            t     <= '0;
            a_out <= '0;
            b_out <= '0;
            sn    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= STREAM;
                        t     <= '0;
                        a_out <= a_lanes;
                        b_out <= b_lanes;
                        sn    <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (t == T_LAST) begin
                        state <= DONE;
                        a_out <= '0;
                        b_out <= '0;
                        sn    <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        t     <= t + 1'b1;
                        a_out <= a_lanes;
                        b_out <= b_lanes;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    t     <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/systolic_skew_feeder.md
SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning element width in bits.
REQ-002 The block SHALL have parameter S, default 8, meaning array dimension (S x S tile, S lanes).
REQ-003 The block SHALL have parameter AW, default 3, meaning row-address width; AW = ceil(log2(S)).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port wr_en, input, 1, tile-row write strobe.
REQ-007 The block SHALL have port wr_sel, input, 1, 0 = write A tile, 1 = write B tile.
REQ-008 The block SHALL have port wr_addr, input, AW, row index 0..S-1.
REQ-009 The block SHALL have port wr_data, input, S*N, one tile row; element j at bits [S*N-1-j*N -: N] (element 0 in MSBs).
REQ-010 The block SHALL have port start, input, 1, launch-stream request.
REQ-011 The block SHALL have port a_out, output, S*N, skewed row-operand lanes; lane r at bits [S*N-1-r*N -: N].
REQ-012 The block SHALL have port b_out, output, S*N, skewed column-operand lanes; lane c at bits [S*N-1-c*N -: N].
REQ-013 The block SHALL have port sn, output, 1, array compute enable to the PE rows.
REQ-014 The block SHALL have port busy, output, 1, high while not IDLE.
REQ-015 The block SHALL have port done, output, 1, single-cycle end-of-stream pulse.

Function
REQ-016 Storage SHALL be two S x S tiles of N-bit registers, A[r][k] and B[k][c].
REQ-017 In IDLE, a cycle with wr_en=1 SHALL write wr_data into row wr_addr of the tile selected by wr_sel at that edge; wr_addr >= S SHALL be ignored.
REQ-018 Writes while busy=1 SHALL be ignored; tile contents SHALL remain stable during a stream.
REQ-019 The FSM SHALL have states IDLE, STREAM, DONE.
REQ-020 IDLE -> STREAM SHALL occur on the edge where start=1; if wr_en and start are both 1 in the same IDLE cycle, the write SHALL complete first and the stream SHALL use the updated tile.
REQ-021 In STREAM, a step counter t SHALL run 0..3S-3 (3S-2 cycles), incrementing each cycle; STREAM -> DONE SHALL occur after t = 3S-3.
REQ-022 DONE SHALL last exactly one cycle, then return to IDLE; start during STREAM or DONE SHALL be ignored (no queuing).
REQ-023 All outputs SHALL be registered; the first STREAM cycle (t=0) values SHALL appear the cycle after start is sampled.
REQ-024 During STREAM at step t, a_out lane r SHALL equal A[r][t-r] when 0 <= t-r <= S-1, else 0.
REQ-025 During STREAM at step t, b_out lane c SHALL equal B[t-c][c] when 0 <= t-c <= S-1, else 0.
REQ-026 Steps 2S-1..3S-3 SHALL output all-zero lanes (drain cycles letting the last operands reach PE (S-1,S-1)).
REQ-027 sn SHALL be 1 for exactly the 3S-2 STREAM cycles and 0 otherwise.
REQ-028 busy SHALL be 1 in STREAM and DONE; done SHALL be 1 only in DONE.
REQ-029 In IDLE and DONE, a_out and b_out SHALL be all zeros.

Reset
REQ-030 rst=0 SHALL immediately (asynchronously) force state IDLE, t=0, a_out=0, b_out=0, sn=0, busy=0, done=0.
REQ-031 rst=0 SHALL clear both tiles to zero.
REQ-032 Reset asserted mid-stream SHALL abort the stream with no done pulse; after release the block SHALL wait for a new start.

Verification
REQ-033 S=4,N=8: load A[r][k]=16r+k, B[k][c]=16k+c+0x80, start -> 10 STREAM cycles; t=0 a_out=00_00_00_00 with lane0=0x00,... t=3 a_out lanes = {0x03,0x12,0x21,0x30}, b_out lanes = {0xB0,0xA1,0x92,0x83}; t=7..9 all zero; sn high 10 cycles; done one cycle after.
REQ-034 Write with wr_en=1 and start=1 same cycle (A row 0 = 0xFF..) -> t=0 a_out lane0 = 0xFF.
REQ-035 start pulsed at t=4 and in DONE -> ignored; exactly one done pulse; write attempted at t=2 -> tile unchanged on next stream.
REQ-036 rst=0 at t=5 -> outputs zero same cycle, no done, busy=0; after release, start -> fresh 3S-2-cycle stream with zeroed tiles (all lanes 0).
REQ-037 Back-to-back: start held high continuously -> streams separated by exactly one IDLE cycle after DONE (STREAM, DONE, IDLE, STREAM).
